hwpe_ctrl_job_scheduler: RTL and testbench
==========================================

Name: hwpe_ctrl_job_scheduler

Overview:
Context-level job scheduler between the peripheral register file and the HWPE engine/uloop.
- Offloading cores acquire one of N_CONTEXT job slots, program the slot, then trigger it.
- Triggered jobs are launched on the engine strictly in allocation order, one at a time.
- On engine completion the block frees the slot and pulses an event to the owning core.

Parameters:
N_CONTEXT, 2, number of job slots (power of two, ≥2); CTX_W = $clog2(N_CONTEXT)
N_CORES, 16, number of offloading cores; CORE_W = $clog2(N_CORES)
N_EVT, 2, event lines per core
CNT_W, 8, width of the finished-jobs counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
softclear_i  in  1  synchronous soft reset of scheduler state, active-high pulse
acquire_req_i  in  1  acquire request, single-cycle pulse
acquire_core_i  in  CORE_W  requesting core ID
acquire_gnt_o  out  1  combinational: a slot is granted this cycle
acquire_id_o  out  CTX_W  combinational: granted slot ID (alloc_ptr)
trigger_i  in  1  commit pulse
trigger_id_i  in  CTX_W  slot being committed
trigger_err_o  out  1  registered pulse: trigger targeted a slot not in ACQUIRED
start_o  out  1  registered one-cycle engine start pulse
running_id_o  out  CTX_W  slot currently running (run_ptr)
busy_o  out  1  high in START and RUN
done_i  in  1  engine completion pulse
done_o  out  1  one-cycle pulse when a job retires
evt_o  out  N_CORES*N_EVT  per-core event pulses; index [core][0] is used
engine_clear_o  out  1  registered copy of softclear_i
nb_finished_o  out  CNT_W  retired-jobs counter
nb_free_o  out  CTX_W+1  number of FREE slots

Behaviour:
- Per-slot state: FREE, ACQUIRED, QUEUED, RUNNING, plus a registered owner core ID.
- Pointers: alloc_ptr and run_ptr, each CTX_W bits, wrap modulo N_CONTEXT.
- Reset (rst_i) and softclear_i have identical effect on the next edge:
  - all slots FREE, both pointers 0, FSM IDLE
  - every output 0, except nb_free_o = N_CONTEXT
  - softclear_i additionally makes engine_clear_o = 1 in the following cycle.
  - Neither reset nor softclear generates events.
- Acquire:
  - acquire_gnt_o = acquire_req_i && slot[alloc_ptr]==FREE; otherwise 0, and the requester retries.
  - On grant: slot becomes ACQUIRED, owner is latched, alloc_ptr increments.
- Trigger:
  - If slot[trigger_id_i]==ACQUIRED, the slot becomes QUEUED next cycle.
  - Otherwise (FREE, QUEUED or RUNNING) state is unchanged and trigger_err_o pulses next cycle.
- FSM IDLE → START when slot[run_ptr]==QUEUED (registered state is sampled).
- START:
  - start_o = 1 for exactly one cycle; the slot becomes RUNNING.
  - Always → RUN.
- RUN:
  - Waits for done_i; done_i in any other state is ignored.
  - On done_i → DONE.
- DONE, one cycle:
  - done_o = 1; evt_o[owner][0] = 1; nb_finished_o increments (wraps at 2^CNT_W).
  - The slot becomes FREE and run_ptr increments.
  - Next state is IDLE. The following IDLE cycle then launches the next slot if it is QUEUED.
- Latency, idle scheduler:
  - trigger at cycle t → start_o at t+2.
  - done_i at cycle d → done_o/evt_o at d+1 → next queued start_o at d+3.
- Simultaneous events:
  - Slot updates from acquire, trigger and DONE target different slots or are ordered by state. They never conflict: the DONE slot is RUNNING, so it cannot be acquired or triggered.
  - Acquire sees pre-edge state: a slot freed in DONE is not grantable in the same cycle.
  - softclear_i has priority over every other input in the same cycle.
- Out-of-order triggers: a QUEUED slot that is not at run_ptr waits until all earlier-allocated slots have retired (strict allocation order).
- nb_free_o is registered and consistent with slot states every cycle.

Decomposition:
- Add to the shared control package:
  - slot-state enum (FREE/ACQUIRED/QUEUED/RUNNING)
  - scheduler-FSM enum (IDLE/START/RUN/DONE)
  - a packed ctrl_sched_t {softclear, acquire_req, acquire_core, trigger, trigger_id}
  - a packed flags_sched_t {acquire_gnt, acquire_id, start, busy, running_id, done, trigger_err, nb_finished}
  These structs let the slave wrapper connect with single struct ports.
- No sub-module: per-slot state/owner registers are a generate loop inside the block.

Test Plan:
- Reset, then core 3 acquires → gnt=1, id=0. Trigger id 0 at t → start_o at t+2, busy_o=1. done_i at d → done_o=1, evt_o[3][0]=1 at d+1; nb_finished_o=1; nb_free_o=2.
- Cores 1 and 2 acquire (ids 0, 1); trigger 1 then 0. Required: start for slot 0 first; slot 1 starts at d+3 after slot 0's done; events go to core 1 then core 2.
- Both slots ACQUIRED, third acquire → gnt=0. Acquire in the DONE cycle of slot 0 → gnt=0. Same acquire on the next cycle → gnt=1, id=0.
- Trigger a FREE slot, then re-trigger a QUEUED slot → trigger_err_o pulses each time; no start_o. done_i while IDLE → no done_o.
- softclear_i asserted during RUN → next cycle: all FREE, busy_o=0, engine_clear_o=1, no evt_o; later done_i is ignored.
- 256 sequential jobs → nb_finished_o wraps from 255 to 0; alloc_ptr and run_ptr wrap with no lost or duplicated start.

Source files
------------

// File: rtl/hwpe_ctrl_job_scheduler_pkg.sv
// Shared control types for the HWPE job scheduler: slot and FSM state encodings
// plus the packed control/flag bundles used by the register-file slave wrapper.
package hwpe_ctrl_job_scheduler_pkg;

  localparam int unsigned SCHED_N_CONTEXT = 2;
  localparam int unsigned SCHED_N_CORES   = 16;
  localparam int unsigned SCHED_CNT_W     = 8;
  localparam int unsigned SCHED_CTX_W     = $clog2(SCHED_N_CONTEXT);
  localparam int unsigned SCHED_CORE_W    = $clog2(SCHED_N_CORES);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_ACQUIRED,
    SLOT_QUEUED,
    SLOT_RUNNING
  } slot_state_e;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_START,
    SCHED_RUN,
    SCHED_DONE
  } sched_state_e;

  typedef struct packed {
    logic                    softclear;
    logic                    acquire_req;
    logic [SCHED_CORE_W-1:0] acquire_core;
    logic                    trigger;
    logic [SCHED_CTX_W-1:0]  trigger_id;
  } ctrl_sched_t;

  typedef struct packed {
    logic                   acquire_gnt;
    logic [SCHED_CTX_W-1:0] acquire_id;
    logic                   start;
    logic                   busy;
    logic [SCHED_CTX_W-1:0] running_id;
    logic                   done;
    logic                   trigger_err;
    logic [SCHED_CNT_W-1:0] nb_finished;
  } flags_sched_t;

endpackage

// File: rtl/hwpe_ctrl_job_scheduler.sv
// Context-level job scheduler: cores acquire and trigger job slots, which are
// launched on the engine one at a time in allocation order and retired with a per-core event.
module hwpe_ctrl_job_scheduler
  import hwpe_ctrl_job_scheduler_pkg::*;
#(
  parameter int unsigned N_CONTEXT = SCHED_N_CONTEXT,
  parameter int unsigned N_CORES   = SCHED_N_CORES,
  parameter int unsigned N_EVT     = 2,
  parameter int unsigned CNT_W     = SCHED_CNT_W,
  localparam int unsigned CTX_W    = $clog2(N_CONTEXT),
  localparam int unsigned CORE_W   = $clog2(N_CORES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       softclear_i,
  input  logic                       acquire_req_i,
  input  logic [CORE_W-1:0]          acquire_core_i,
  output logic                       acquire_gnt_o,
  output logic [CTX_W-1:0]           acquire_id_o,
  input  logic                       trigger_i,
  input  logic [CTX_W-1:0]           trigger_id_i,
  output logic                       trigger_err_o,
  output logic                       start_o,
  output logic [CTX_W-1:0]           running_id_o,
  output logic                       busy_o,
  input  logic                       done_i,
  output logic                       done_o,
  output logic [N_CORES*N_EVT-1:0]   evt_o,
  output logic                       engine_clear_o,
  output logic [CNT_W-1:0]           nb_finished_o,
  output logic [CTX_W:0]             nb_free_o
);

  slot_state_e [N_CONTEXT-1:0]             slot_state;
  logic        [N_CONTEXT-1:0][CORE_W-1:0] slot_owner;

  sched_state_e             state_q;
  logic [CTX_W-1:0]         alloc_ptr_q, run_ptr_q;
  logic                     start_q, busy_q, done_q, trigger_err_q, engine_clear_q;
  logic [N_CORES*N_EVT-1:0] evt_q;
  logic [CNT_W-1:0]         nb_finished_q;
  logic [CTX_W:0]           nb_free_q, nb_free_d;
  logic                     clear;
  logic                     trigger_ok;

  function automatic logic [N_CORES*N_EVT-1:0] core_evt(input logic [CORE_W-1:0] core);
    core_evt = '0;
    for (int c = 0; c < N_CORES; c++) core_evt[c*N_EVT] = (core == CORE_W'(c));
  endfunction

  assign clear = rst_i | softclear_i;

  // Grant looks at pre-edge slot state, so a slot retiring this cycle is not yet grantable.
  assign acquire_gnt_o = acquire_req_i && !clear && (slot_state[alloc_ptr_q] == SLOT_FREE);
  assign trigger_ok    = trigger_i && (slot_state[trigger_id_i] == SLOT_ACQUIRED);

  for (genvar i = 0; i < N_CONTEXT; i++) begin : g_slot
    slot_state_e       slot_q, slot_d;
    logic [CORE_W-1:0] owner_q;
    logic              hit_alloc, hit_run;

    assign hit_alloc = acquire_gnt_o && (alloc_ptr_q == CTX_W'(i));
    assign hit_run   = (run_ptr_q == CTX_W'(i));

    // NOTE: slot_d takes a default first so no path through this block leaves it unassigned (no latch).
    always_comb begin
      slot_d = slot_q;
      if (hit_alloc) slot_d = SLOT_ACQUIRED;
      if (trigger_ok && trigger_id_i == CTX_W'(i)) slot_d = SLOT_QUEUED;
      if (hit_run && state_q == SCHED_START) slot_d = SLOT_RUNNING;
      if (hit_run && state_q == SCHED_DONE) slot_d = SLOT_FREE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
      if (clear) begin
        slot_q  <= SLOT_FREE;
        owner_q <= '0;
      end else begin
        slot_q <= slot_d;
        if (hit_alloc) owner_q <= acquire_core_i;
      end
    end

    assign slot_state[i] = slot_q;
    assign slot_owner[i] = owner_q;
  end

  always_comb begin
    nb_free_d = nb_free_q;
    if (acquire_gnt_o) nb_free_d = nb_free_d - (CTX_W+1)'(1);
    if (state_q == SCHED_DONE) nb_free_d = nb_free_d + (CTX_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q       <= SCHED_IDLE;
      alloc_ptr_q   <= '0;
      run_ptr_q     <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      evt_q         <= '0;
      trigger_err_q <= 1'b0;
      nb_finished_q <= '0;
      nb_free_q     <= (CTX_W+1)'(N_CONTEXT);
    end else begin
      nb_free_q     <= nb_free_d;
      trigger_err_q <= trigger_i && !trigger_ok;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      evt_q         <= '0;
      if (acquire_gnt_o) alloc_ptr_q <= alloc_ptr_q + CTX_W'(1);
      case (state_q)
        SCHED_IDLE: if (slot_state[run_ptr_q] == SLOT_QUEUED) begin
          state_q <= SCHED_START;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        SCHED_START: state_q <= SCHED_RUN;
        SCHED_RUN: if (done_i) begin
          state_q <= SCHED_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          evt_q   <= core_evt(slot_owner[run_ptr_q]);
        end
        SCHED_DONE: begin
          state_q       <= SCHED_IDLE;
          run_ptr_q     <= run_ptr_q + CTX_W'(1);
          nb_finished_q <= nb_finished_q + CNT_W'(1);
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) engine_clear_q <= softclear_i && !rst_i;

  assign acquire_id_o   = alloc_ptr_q;
  assign running_id_o   = run_ptr_q;
  assign trigger_err_o  = trigger_err_q;
  assign start_o        = start_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign evt_o          = evt_q;
  assign engine_clear_o = engine_clear_q;
  assign nb_finished_o  = nb_finished_q;
  assign nb_free_o      = nb_free_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_scheduler.sv
// Self-checking bench for hwpe_ctrl_job_scheduler: directed scenarios plus a randomized
// multi-job run against an allocation-order queue model.
module tb_hwpe_ctrl_job_scheduler;

  localparam int N_CONTEXT = 2;
  localparam int N_CORES   = 16;
  localparam int N_EVT     = 2;
  localparam int CNT_W     = 8;
  localparam int CTX_W     = 1;
  localparam int CORE_W    = 4;
  localparam int EVT_W     = N_CORES * N_EVT;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              softclear_i = 1'b0;
  logic              acquire_req_i = 1'b0;
  logic [CORE_W-1:0] acquire_core_i = '0;
  logic              acquire_gnt_o;
  logic [CTX_W-1:0]  acquire_id_o;
  logic              trigger_i = 1'b0;
  logic [CTX_W-1:0]  trigger_id_i = '0;
  logic              trigger_err_o;
  logic              start_o;
  logic [CTX_W-1:0]  running_id_o;
  logic              busy_o;
  logic              done_i = 1'b0;
  logic              done_o;
  logic [EVT_W-1:0]  evt_o;
  logic              engine_clear_o;
  logic [CNT_W-1:0]  nb_finished_o;
  logic [CTX_W:0]    nb_free_o;

  hwpe_ctrl_job_scheduler #(
    .N_CONTEXT(N_CONTEXT), .N_CORES(N_CORES), .N_EVT(N_EVT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .softclear_i(softclear_i),
    .acquire_req_i(acquire_req_i), .acquire_core_i(acquire_core_i),
    .acquire_gnt_o(acquire_gnt_o), .acquire_id_o(acquire_id_o),
    .trigger_i(trigger_i), .trigger_id_i(trigger_id_i), .trigger_err_o(trigger_err_o),
    .start_o(start_o), .running_id_o(running_id_o), .busy_o(busy_o),
    .done_i(done_i), .done_o(done_o), .evt_o(evt_o), .engine_clear_o(engine_clear_o),
    .nb_finished_o(nb_finished_o), .nb_free_o(nb_free_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_dones  = 0;

  always @(negedge clk_i) begin
    if (start_o === 1'b1) n_starts++;
    if (done_o === 1'b1) n_dones++;
  end

  // Reference model: outstanding jobs kept in allocation order.
  int m_alloc, m_run, m_fin;
  int m_owner_q[$];

  function automatic logic [EVT_W-1:0] exp_evt(input int core);
    logic [EVT_W-1:0] e;
    e = '0;
    e[core*N_EVT] = 1'b1;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    acquire_req_i = 1'b0; trigger_i = 1'b0; done_i = 1'b0; softclear_i = 1'b0;
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    m_alloc = 0; m_run = 0; m_fin = 0;
    m_owner_q.delete();
  endtask

  task automatic acquire(input int core, output logic gnt, output logic [CTX_W-1:0] id);
    acquire_req_i  = 1'b1;
    acquire_core_i = CORE_W'(core);
    #1;
    gnt = acquire_gnt_o;
    id  = acquire_id_o;
    cyc();
    acquire_req_i = 1'b0;
  endtask

  task automatic trigger(input int id);
    trigger_i    = 1'b1;
    trigger_id_i = CTX_W'(id);
    cyc();
    trigger_i = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (start_o !== 1'b1 && waited < 64) begin
      cyc();
      waited++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({start_o, busy_o, done_o, trigger_err_o, engine_clear_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {start_o, busy_o, done_o, trigger_err_o, engine_clear_o}); end
    n_checks++; if (evt_o !== '0) begin
      n_fail++; $display("FAIL reset_evt: got %h expected 0", evt_o); end
    n_checks++; if (nb_finished_o !== '0) begin
      n_fail++; $display("FAIL reset_nb_finished: got %0d expected 0", nb_finished_o); end
    n_checks++; if (nb_free_o !== 2'(N_CONTEXT)) begin
      n_fail++; $display("FAIL reset_nb_free: got %0d expected %0d", nb_free_o, N_CONTEXT); end
    n_checks++; if ({acquire_gnt_o, acquire_id_o, running_id_o} !== 3'b0) begin
      n_fail++; $display("FAIL reset_ids: got %b expected 000", {acquire_gnt_o, acquire_id_o, running_id_o}); end
  endtask

  task automatic test_single_job();
    logic gnt; logic [CTX_W-1:0] id;
    do_reset();
    acquire(3, gnt, id);
    n_checks++; if ({gnt, id} !== 2'b10) begin
      n_fail++; $display("FAIL single_acquire: got gnt=%b id=%0d expected gnt=1 id=0", gnt, id); end
    trigger(0);
    n_checks++; if (start_o !== 1'b0) begin
      n_fail++; $display("FAIL single_start_t1: got %b expected 0", start_o); end
    cyc();
    n_checks++; if ({start_o, busy_o, running_id_o} !== 3'b110) begin
      n_fail++; $display("FAIL single_start_t2: got start/busy/id=%b expected 110", {start_o, busy_o, running_id_o}); end
    cyc();
    n_checks++; if ({start_o, busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL single_run: got start/busy=%b expected 01", {start_o, busy_o}); end
    cyc(); cyc();
    pulse_done();
    n_checks++; if ({done_o, busy_o} !== 2'b10 || evt_o !== exp_evt(3)) begin
      n_fail++; $display("FAIL single_done: got done/busy=%b evt=%h expected 10 evt=%h", {done_o, busy_o}, evt_o, exp_evt(3)); end
    cyc();
    n_checks++; if (done_o !== 1'b0 || evt_o !== '0 || nb_finished_o !== 8'd1 || nb_free_o !== 2'd2) begin
      n_fail++; $display("FAIL single_retire: got done=%b evt=%h fin=%0d free=%0d expected 0 0 1 2", done_o, evt_o, nb_finished_o, nb_free_o); end
  endtask

  task automatic test_order();
    logic gnt; logic [CTX_W-1:0] id;
    do_reset();
    acquire(1, gnt, id);
    n_checks++; if ({gnt, id} !== 2'b10) begin
      n_fail++; $display("FAIL order_acq_a: got gnt=%b id=%0d expected 1 0", gnt, id); end
    acquire(2, gnt, id);
    n_checks++; if ({gnt, id} !== 2'b11) begin
      n_fail++; $display("FAIL order_acq_b: got gnt=%b id=%0d expected 1 1", gnt, id); end
    n_checks++; if (nb_free_o !== 2'd0) begin
      n_fail++; $display("FAIL order_nb_free: got %0d expected 0", nb_free_o); end
    trigger(1);
    trigger(0);
    n_checks++; if (start_o !== 1'b0) begin
      n_fail++; $display("FAIL order_no_early_start: got %b expected 0", start_o); end
    cyc();
    n_checks++; if ({start_o, running_id_o} !== 2'b10) begin
      n_fail++; $display("FAIL order_first_start: got start/id=%b expected 10", {start_o, running_id_o}); end
    cyc(); cyc(); cyc();
    pulse_done();
    n_checks++; if (evt_o !== exp_evt(1)) begin
      n_fail++; $display("FAIL order_evt_core1: got %h expected %h", evt_o, exp_evt(1)); end
    cyc();
    n_checks++; if (start_o !== 1'b0) begin
      n_fail++; $display("FAIL order_gap_d2: got %b expected 0", start_o); end
    cyc();
    n_checks++; if ({start_o, running_id_o} !== 2'b11) begin
      n_fail++; $display("FAIL order_second_start_d3: got start/id=%b expected 11", {start_o, running_id_o}); end
    cyc(); cyc();
    pulse_done();
    n_checks++; if (evt_o !== exp_evt(2)) begin
      n_fail++; $display("FAIL order_evt_core2: got %h expected %h", evt_o, exp_evt(2)); end
    cyc();
    n_checks++; if (nb_finished_o !== 8'd2 || nb_free_o !== 2'd2) begin
      n_fail++; $display("FAIL order_final: got fin=%0d free=%0d expected 2 2", nb_finished_o, nb_free_o); end
  endtask

  task automatic test_full();
    logic gnt; logic [CTX_W-1:0] id;
    do_reset();
    acquire(4, gnt, id);
    acquire(5, gnt, id);
    acquire(6, gnt, id);
    n_checks++; if (gnt !== 1'b0) begin
      n_fail++; $display("FAIL full_third_acquire: got gnt=%b expected 0", gnt); end
    trigger(0);
    cyc();
    n_checks++; if (start_o !== 1'b1) begin
      n_fail++; $display("FAIL full_start: got %b expected 1", start_o); end
    cyc();
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    acquire_req_i = 1'b1; acquire_core_i = 4'd9;
    #1;
    n_checks++; if ({done_o, acquire_gnt_o} !== 2'b10) begin
      n_fail++; $display("FAIL full_acquire_in_done: got done/gnt=%b expected 10", {done_o, acquire_gnt_o}); end
    cyc();
    n_checks++; if ({acquire_gnt_o, acquire_id_o} !== 2'b10) begin
      n_fail++; $display("FAIL full_acquire_after_done: got gnt/id=%b expected 10", {acquire_gnt_o, acquire_id_o}); end
    cyc();
    acquire_req_i = 1'b0;
    n_checks++; if (nb_free_o !== 2'd0) begin
      n_fail++; $display("FAIL full_nb_free: got %0d expected 0", nb_free_o); end
  endtask

  task automatic test_trigger_err();
    logic gnt; logic [CTX_W-1:0] id; int s0;
    do_reset();
    trigger(0);
    n_checks++; if (trigger_err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_free_slot: got %b expected 1", trigger_err_o); end
    cyc();
    n_checks++; if (trigger_err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: got %b expected 0", trigger_err_o); end
    acquire(6, gnt, id);
    acquire(7, gnt, id);
    s0 = n_starts;
    trigger(1);
    n_checks++; if (trigger_err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_valid_trigger: got %b expected 0", trigger_err_o); end
    trigger(1);
    n_checks++; if (trigger_err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_queued_retrigger: got %b expected 1", trigger_err_o); end
    repeat (4) cyc();
    n_checks++; if (n_starts != s0) begin
      n_fail++; $display("FAIL err_no_start: got %0d starts expected 0", n_starts - s0); end
    pulse_done();
    n_checks++; if (done_o !== 1'b0 || evt_o !== '0) begin
      n_fail++; $display("FAIL err_done_in_idle: got done=%b evt=%h expected 0 0", done_o, evt_o); end
    cyc();
    n_checks++; if (nb_finished_o !== 8'd0) begin
      n_fail++; $display("FAIL err_done_in_idle_cnt: got %0d expected 0", nb_finished_o); end
  endtask

  task automatic test_softclear();
    logic gnt; logic [CTX_W-1:0] id; int w; int s0;
    do_reset();
    acquire(7, gnt, id);
    trigger(0);
    wait_start(w);
    cyc(); cyc();
    softclear_i = 1'b1;
    cyc();
    softclear_i = 1'b0;
    s0 = n_starts;
    n_checks++; if ({busy_o, engine_clear_o, start_o, done_o} !== 4'b0100 || evt_o !== '0 || nb_free_o !== 2'd2) begin
      n_fail++; $display("FAIL softclear_state: got busy/eclr/start/done=%b evt=%h free=%0d expected 0100 0 2",
        {busy_o, engine_clear_o, start_o, done_o}, evt_o, nb_free_o); end
    cyc();
    n_checks++; if (engine_clear_o !== 1'b0) begin
      n_fail++; $display("FAIL softclear_eclr_pulse: got %b expected 0", engine_clear_o); end
    pulse_done();
    n_checks++; if (done_o !== 1'b0 || evt_o !== '0) begin
      n_fail++; $display("FAIL softclear_done_ignored: got done=%b evt=%h expected 0 0", done_o, evt_o); end
    cyc();
    n_checks++; if (nb_finished_o !== 8'd0 || busy_o !== 1'b0 || n_starts != s0) begin
      n_fail++; $display("FAIL softclear_after: got fin=%0d busy=%b starts=%0d expected 0 0 0", nb_finished_o, busy_o, n_starts - s0); end
    acquire(8, gnt, id);
    n_checks++; if ({gnt, id} !== 2'b10) begin
      n_fail++; $display("FAIL softclear_reacquire: got gnt=%b id=%0d expected 1 0", gnt, id); end
  endtask

  task automatic test_random_wrap();
    logic gnt; logic [CTX_W-1:0] id;
    int jobs, k, core, w, owner, s0, d0;
    int ids[$];
    do_reset();
    jobs = 0; s0 = n_starts; d0 = n_dones;
    while (jobs < 300) begin
      k = $urandom_range(1, 2);
      ids.delete();
      for (int j = 0; j < k; j++) begin
        core = $urandom_range(0, N_CORES - 1);
        acquire(core, gnt, id);
        n_checks++; if (gnt !== 1'b1 || int'(id) != m_alloc) begin
          n_fail++; $display("FAIL rnd_acquire: got gnt=%b id=%0d expected 1 %0d", gnt, id, m_alloc); end
        ids.push_back(m_alloc);
        m_owner_q.push_back(core);
        m_alloc = (m_alloc + 1) % N_CONTEXT;
      end
      if (m_owner_q.size() == N_CONTEXT && $urandom_range(0, 1) == 1) begin
        acquire($urandom_range(0, N_CORES - 1), gnt, id);
        n_checks++; if (gnt !== 1'b0) begin
          n_fail++; $display("FAIL rnd_acquire_full: got gnt=%b expected 0", gnt); end
      end
      if (k == 2 && $urandom_range(0, 1) == 1) begin
        trigger(ids[1]); trigger(ids[0]);
      end else begin
        foreach (ids[j]) trigger(ids[j]);
      end
      while (m_owner_q.size() > 0) begin
        wait_start(w);
        n_checks++; if (w >= 64 || int'(running_id_o) != m_run) begin
          n_fail++; $display("FAIL rnd_start: got waited=%0d id=%0d expected start with id %0d", w, running_id_o, m_run); end
        repeat ($urandom_range(1, 4)) cyc();
        pulse_done();
        owner = m_owner_q.pop_front();
        n_checks++; if (done_o !== 1'b1 || evt_o !== exp_evt(owner)) begin
          n_fail++; $display("FAIL rnd_done: got done=%b evt=%h expected 1 %h", done_o, evt_o, exp_evt(owner)); end
        m_fin++;
        m_run = (m_run + 1) % N_CONTEXT;
        jobs++;
        cyc();
        n_checks++; if (int'(nb_finished_o) != m_fin % 256) begin
          n_fail++; $display("FAIL rnd_nb_finished: got %0d expected %0d", nb_finished_o, m_fin % 256); end
      end
    end
    n_checks++; if (n_starts - s0 != jobs || n_dones - d0 != jobs) begin
      n_fail++; $display("FAIL rnd_counts: got starts=%0d dones=%0d expected %0d", n_starts - s0, n_dones - d0, jobs); end
    n_checks++; if (nb_free_o !== 2'd2 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rnd_final: got free=%0d busy=%b expected 2 0", nb_free_o, busy_o); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_job();
    test_order();
    test_full();
    test_trigger_err();
    test_softclear();
    test_random_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
